// File: rtl/pad_in_filter_if.sv
// Signal bundle between the pad-input filter and the register/pad logic that drives it.
// The master side drives the raw pads and configuration; the slave (the filter) returns levels, events and flags.
interface pad_in_filter_if #(
    parameter int NUM_PADS = 32,
    parameter int CNT_W    = 8
);
    logic [NUM_PADS-1:0] pad_in_i;
    logic                filt_en_i;
    logic [CNT_W-1:0]    filt_len_i;
    logic [NUM_PADS-1:0] rise_en_i;
    logic [NUM_PADS-1:0] fall_en_i;
    logic [NUM_PADS-1:0] clr_i;
    logic [NUM_PADS-1:0] filt_o;
    logic [NUM_PADS-1:0] rise_o;
    logic [NUM_PADS-1:0] fall_o;
    logic [NUM_PADS-1:0] pending_o;
    logic                irq_o;

    modport master (
        output pad_in_i, filt_en_i, filt_len_i, rise_en_i, fall_en_i, clr_i,
        input  filt_o, rise_o, fall_o, pending_o, irq_o
    );

    modport slave (
        input  pad_in_i, filt_en_i, filt_len_i, rise_en_i, fall_en_i, clr_i,
        output filt_o, rise_o, fall_o, pending_o, irq_o
    );
endinterface

// File: rtl/pad_in_filter.sv
// Per-pad synchronizer + debounce filter with edge pulses, sticky pending flags and a combined interrupt.
// Every channel is independent; only the filter length and enable are shared.
module pad_in_filter #(
    parameter int NUM_PADS = 32,
    parameter int CNT_W    = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    pad_in_filter_if.slave bus
);
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [NUM_PADS-1:0] vec_t;

    localparam cnt_t CNT_ONE = CNT_W'(1);

    vec_t sync1_q, sync2_q;
    vec_t stable_q, stable_d;
    vec_t stable_dly_q;
    vec_t rise_q, rise_d;
    vec_t fall_q, fall_d;
    vec_t pending_q, pending_d;
    cnt_t cnt_q [NUM_PADS];
    cnt_t cnt_d [NUM_PADS];
    cnt_t leff_m1;

    // Leff-1 is compared with >= so a length shrinking mid-count commits at once instead of wrapping.
    always_comb begin
        leff_m1 = '0;
        if (bus.filt_en_i && (bus.filt_len_i != '0)) begin
            leff_m1 = bus.filt_len_i - CNT_ONE;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_PADS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= leff_m1) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end

        rise_d    = stable_q & ~stable_dly_q;
        fall_d    = ~stable_q & stable_dly_q;
        pending_d = (rise_d & bus.rise_en_i) | (fall_d & bus.fall_en_i) | (pending_q & ~bus.clr_i);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            pending_q    <= '0;
            // NOTE: the counter array is per-channel flops, not RAM, and must reset so an aborted count leaves no residue.
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= bus.pad_in_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            pending_q    <= pending_d;
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.filt_o    = stable_q;
    assign bus.rise_o    = rise_q;
    assign bus.fall_o    = fall_q;
    assign bus.pending_o = pending_q;
    assign bus.irq_o     = |pending_q;
endmodule

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter: latency, glitch rejection, length change, pending/clear, reset abort,
// followed by a randomized toggling run checked cycle-by-cycle against a behavioural model.
module tb_pad_in_filter;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pad_in_filter_if #(.NUM_PADS(32), .CNT_W(8)) bus ();

    pad_in_filter #(.NUM_PADS(32), .CNT_W(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] m_s1, m_s2, m_st, m_dly, m_rise, m_fall, m_pend;
    logic [7:0]  m_cnt [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_st = '0; m_dly = '0;
        m_rise = '0; m_fall = '0; m_pend = '0;
        for (int i = 0; i < 32; i++) m_cnt[i] = '0;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [7:0]  lm1;
        logic [31:0] n_st;
        lm1  = (bus.filt_en_i && bus.filt_len_i != 8'd0) ? bus.filt_len_i - 8'd1 : 8'd0;
        n_st = m_st;
        for (int i = 0; i < 32; i++) begin
            if (m_s2[i] != m_st[i]) begin
                if (m_cnt[i] >= lm1) begin
                    n_st[i]  = m_s2[i];
                    m_cnt[i] = 8'd0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 8'd1;
                end
            end else begin
                m_cnt[i] = 8'd0;
            end
        end
        m_rise = m_st & ~m_dly;
        m_fall = ~m_st & m_dly;
        m_pend = (m_rise & bus.rise_en_i) | (m_fall & bus.fall_en_i) | (m_pend & ~bus.clr_i);
        m_dly  = m_st;
        m_st   = n_st;
        m_s2   = m_s1;
        m_s1   = bus.pad_in_i;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.pad_in_i   = '0;
        bus.filt_en_i  = 1'b0;
        bus.filt_len_i = '0;
        bus.rise_en_i  = '0;
        bus.fall_en_i  = '0;
        bus.clr_i      = '0;
        tick(2);
        check("rst_filt", bus.filt_o, 32'h0);
        check("rst_rise", bus.rise_o, 32'h0);
        check("rst_fall", bus.fall_o, 32'h0);
        check("rst_pend", bus.pending_o, 32'h0);
        check("rst_irq", 32'(bus.irq_o), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Unfiltered rise on pad 0: level at edge 3, pulse at edge 4.
        bus.rise_en_i    = 32'h1;
        bus.pad_in_i[0]  = 1'b1;
        tick(2);
        check("nofilt_e2_filt", bus.filt_o, 32'h0);
        tick(1);
        check("nofilt_e3_filt", bus.filt_o, 32'h1);
        check("nofilt_e3_rise", bus.rise_o, 32'h0);
        tick(1);
        check("nofilt_e4_rise", bus.rise_o, 32'h1);
        check("nofilt_e4_pend", bus.pending_o, 32'h1);
        check("nofilt_e4_irq", 32'(bus.irq_o), 32'h1);
        tick(1);
        check("nofilt_e5_rise", bus.rise_o, 32'h0);
        bus.clr_i = 32'h1;
        tick(1);
        bus.clr_i = '0;
        check("clr0_pend", bus.pending_o, 32'h0);
        check("clr0_irq", 32'(bus.irq_o), 32'h0);
        bus.pad_in_i[0] = 1'b0;
        tick(3);
        check("fall0_filt", bus.filt_o, 32'h0);
        tick(1);
        check("fall0_pulse", bus.fall_o, 32'h1);
        check("fall0_noen_pend", bus.pending_o, 32'h0);
        tick(2);

        // Length 5 on pad 3: level at edge 7, then a 4-cycle glitch must be swallowed.
        bus.filt_en_i   = 1'b1;
        bus.filt_len_i  = 8'd5;
        bus.pad_in_i[3] = 1'b1;
        tick(6);
        check("len5_e6_filt", bus.filt_o, 32'h0);
        tick(1);
        check("len5_e7_filt", bus.filt_o, 32'h8);
        tick(1);
        check("len5_e8_rise", bus.rise_o, 32'h8);
        tick(2);
        bus.pad_in_i[3] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) bus.pad_in_i[3] = 1'b1;
            tick(1);
            check("glitch_filt", bus.filt_o, 32'h8);
            check("glitch_evt", bus.rise_o | bus.fall_o, 32'h0);
        end

        // Shrinking the length mid-count on pad 5 commits on the next edge.
        bus.pad_in_i[5] = 1'b1;
        tick(5);
        check("shrink_e5_filt", bus.filt_o, 32'h8);
        bus.filt_len_i = 8'd2;
        tick(1);
        check("shrink_e6_filt", bus.filt_o, 32'h28);
        tick(1);
        check("shrink_e7_rise", bus.rise_o, 32'h20);
        bus.filt_len_i = 8'd5;

        // Set and clear colliding on pad 7: set wins, a lone clear then empties it.
        bus.filt_en_i   = 1'b0;
        bus.rise_en_i   = 32'h80;
        bus.pad_in_i[7] = 1'b1;
        tick(3);
        check("coll_filt", bus.filt_o, 32'hA8);
        check("coll_pre_pend", bus.pending_o, 32'h0);
        bus.clr_i = 32'h80;
        tick(1);
        check("coll_set_wins", bus.pending_o, 32'h80);
        check("coll_rise", bus.rise_o, 32'h80);
        tick(1);
        bus.clr_i = '0;
        check("coll_clr_pend", bus.pending_o, 32'h0);
        check("coll_clr_irq", 32'(bus.irq_o), 32'h0);

        // Reset mid-count on pad 9 (counter at 3 of 5), then release with pads held high.
        bus.filt_en_i   = 1'b1;
        bus.filt_len_i  = 8'd5;
        bus.rise_en_i   = 32'h200;
        bus.pad_in_i[9] = 1'b1;
        tick(5);
        check("abort_pre_filt", bus.filt_o, 32'hA8);
        rst_n = 1'b0;
        #1;
        check("abort_filt", bus.filt_o, 32'h0);
        check("abort_rise", bus.rise_o, 32'h0);
        check("abort_fall", bus.fall_o, 32'h0);
        check("abort_pend", bus.pending_o, 32'h0);
        check("abort_irq", 32'(bus.irq_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(7);
        check("rel_e7_filt", bus.filt_o, 32'h2A8);
        check("rel_e7_rise", bus.rise_o, 32'h0);
        tick(1);
        check("rel_e8_rise", bus.rise_o, 32'h2A8);
        check("rel_e8_pend", bus.pending_o, 32'h200);
        check("rel_e8_irq", 32'(bus.irq_o), 32'h1);

        // Random toggling on all channels against the model.
        rst_n = 1'b0;
        bus.pad_in_i  = '0;
        bus.rise_en_i = '0;
        bus.fall_en_i = '0;
        bus.clr_i     = '0;
        tick(1);
        model_reset();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.pad_in_i  = bus.pad_in_i ^ ($urandom & $urandom);
            if (cyc % 40 == 0) begin
                bus.filt_en_i  = 1'($urandom_range(0, 1));
                bus.filt_len_i = 8'($urandom_range(0, 3));
            end
            bus.rise_en_i = $urandom;
            bus.fall_en_i = $urandom;
            bus.clr_i     = $urandom & $urandom & $urandom;
            model_step();
            tick(1);
            check("rnd_filt", bus.filt_o, m_st);
            check("rnd_rise", bus.rise_o, m_rise);
            check("rnd_fall", bus.fall_o, m_fall);
            check("rnd_pend", bus.pending_o, m_pend);
            check("rnd_irq", 32'(bus.irq_o), 32'(|m_pend));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pad_in_filter.md
PAD_IN_FILTER -- requirements
Module: pad_in_filter

Interface
REQ-001 The block SHALL have parameter NUM_PADS, default 32: number of filtered pad input channels.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the debounce length and of each per-channel counter.
REQ-003 The block SHALL have port clk_i, input, 1: the single clock.
REQ-004 The block SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port pad_in_i, input, NUM_PADS: raw pad-frame input values (in_*_o), asynchronous to clk_i.
REQ-006 The block SHALL have port filt_en_i, input, 1: global debounce enable.
REQ-007 The block SHALL have port filt_len_i, input, CNT_W: required stable cycles L.
REQ-008 The block SHALL have port rise_en_i, input, NUM_PADS: per-channel rising-edge event enable.
REQ-009 The block SHALL have port fall_en_i, input, NUM_PADS: per-channel falling-edge event enable.
REQ-010 The block SHALL have port clr_i, input, NUM_PADS: per-channel pending-clear, one-cycle pulse.
REQ-011 The block SHALL have port filt_o, output, NUM_PADS: synchronized, debounced level.
REQ-012 The block SHALL have port rise_o, output, NUM_PADS: one-cycle pulse on each filtered 0->1 transition.
REQ-013 The block SHALL have port fall_o, output, NUM_PADS: one-cycle pulse on each filtered 1->0 transition.
REQ-014 The block SHALL have port pending_o, output, NUM_PADS: sticky event flags.
REQ-015 The block SHALL have port irq_o, output, 1: OR of all pending_o bits.

Function
REQ-016 Each channel SHALL pass pad_in_i through a 2-flop synchronizer; the second flop is "sync".
REQ-017 Each channel SHALL hold a stable register (driving filt_o) and a CNT_W-bit counter.
REQ-018 The effective length SHALL be Leff = 1 when filt_en_i=0 or filt_len_i=0, and Leff = filt_len_i otherwise.
REQ-019 While sync == stable, the counter SHALL clear to 0 each cycle.
REQ-020 While sync != stable and counter < Leff-1, the counter SHALL increment by 1.
REQ-021 While sync != stable and counter >= Leff-1, stable SHALL take sync and the counter SHALL clear to 0.
REQ-022 A pad_in_i change held constant SHALL therefore reach filt_o exactly 2+Leff clock edges after first sampling (3 edges when filtering is disabled).
REQ-023 A glitch that returns to the stable value before Leff cycles have elapsed SHALL leave filt_o, rise_o and fall_o unchanged and SHALL reset the counter.
REQ-024 A mid-count change of filt_len_i SHALL take effect immediately via the >= comparison; the counter SHALL never wrap.
REQ-025 rise_o/fall_o SHALL be registered and SHALL assert for one cycle, on the cycle after stable changes, regardless of the enables.
REQ-026 pending_o[i] SHALL set on the cycle after a stable change when the matching rise_en_i[i]/fall_en_i[i] is 1, and SHALL clear on clr_i[i].
REQ-027 If a set and clr_i[i] occur in the same cycle, the set SHALL win.
REQ-028 irq_o SHALL be the combinational OR of pending_o.
REQ-029 Channels SHALL be fully independent; there SHALL be no cross-channel state.

Reset
REQ-030 While rst_ni=0, the synchronizer flops, stable, counters, rise_o, fall_o, pending_o and irq_o SHALL all be 0.
REQ-031 Reset assertion mid-count SHALL abort the count with no event generated.
REQ-032 A pad held high through reset release SHALL produce rise_o 3+Leff edges after release; pending SHALL set only if rise_en_i is 1.

Verification
REQ-033 filt_en_i=0; pad_in_i[0] 0->1 held -> filt_o[0]=1 at edge 3, rise_o[0] pulse at edge 4, pending_o[0]=1 and irq_o=1 when rise_en_i[0]=1.
REQ-034 filt_en_i=1, filt_len_i=5; 1 is held on pad 3 -> filt_o[3] rises at edge 7; a 4-cycle glitch gives no filt_o change and no events.
REQ-035 filt_len_i=5; pad high for 3 cycles, then filt_len_i set to 2 -> filt_o updates on the next differing cycle with no counter wrap.
REQ-036 Pending set and clr_i on the same cycle -> pending_o stays 1; clr_i alone next cycle -> pending_o=0, irq_o=0.
REQ-037 rst_ni pulled low with counter=3 of 5 -> all outputs 0 immediately; after release with pad high -> rise_o at edge 3+5.
REQ-038 Random per-channel toggling across 32 channels against a reference model -> filt_o, rise_o, fall_o and pending_o match every cycle.
